// File: rtl/lcla_pipe_adder_if.sv
// lcla_pipe_adder_if: operand and result channels of the pipelined lookahead adder
interface lcla_pipe_adder_if #(
  parameter int WIDTH = 16
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             op_valid;
  logic             op_ready;
  logic [WIDTH-1:0] s;
  logic             cout;
  logic             ovf;
  logic             res_valid;
  logic             res_ready;
  modport master (
    output a, b, cin, sub, op_valid, res_ready,
    input  op_ready, s, cout, ovf, res_valid
  );
  modport slave (
    input  a, b, cin, sub, op_valid, res_ready,
    output op_ready, s, cout, ovf, res_valid
  );
endinterface

// File: rtl/lcla_pipe_adder.sv
// lcla_pipe_adder: pipelined carry-lookahead adder/subtractor with valid/ready handshake
module lcla_pipe_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input logic            clk,
  input logic            rst_n,
  lcla_pipe_adder_if.slave io
);
  localparam int CW = WIDTH / STAGES;
  localparam int NG = CW / 4;
  logic en;
  // Two-level lookahead: 4-bit groups, then a flat lookahead across the groups.
  function automatic logic [CW:0] cla_slice(input logic [CW-1:0] a, input logic [CW-1:0] b, input logic ci);
    logic [CW-1:0] g, p, c;
    logic [NG-1:0] gg, gp;
    logic [NG:0]   gc;
    logic          t;
    g = a & b;
    p = a ^ b;
    for (int j = 0; j < NG; j++) begin
      gp[j] = &p[4*j +: 4];
      gg[j] = g[4*j+3] | (p[4*j+3] & g[4*j+2]) | ((&p[4*j+2 +: 2]) & g[4*j+1]) | ((&p[4*j+1 +: 3]) & g[4*j]);
    end
    for (int j = 0; j <= NG; j++) begin
      t = ci;
      for (int m = 0; m < j; m++) t &= gp[m];
      gc[j] = t;
      for (int i = 0; i < j; i++) begin
        t = gg[i];
        for (int m = i + 1; m < j; m++) t &= gp[m];
        gc[j] |= t;
      end
    end
    for (int j = 0; j < NG; j++) begin
      c[4*j]   = gc[j];
      c[4*j+1] = g[4*j] | (p[4*j] & gc[j]);
      c[4*j+2] = g[4*j+1] | (p[4*j+1] & g[4*j]) | ((&p[4*j +: 2]) & gc[j]);
      c[4*j+3] = g[4*j+2] | (p[4*j+2] & g[4*j+1]) | ((&p[4*j+1 +: 2]) & g[4*j]) | ((&p[4*j +: 3]) & gc[j]);
    end
    return {gc[NG], p ^ c};
  endfunction
  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int RW = WIDTH - k * CW;
    logic [RW-1:0]       a_d, b_d;
    logic                c_d, v_d, v_q, c_q, co;
    logic [CW-1:0]       sum;
    logic [(k+1)*CW-1:0] s_q;
    assign {co, sum} = cla_slice(a_d[CW-1:0], b_d[CW-1:0], c_d);
    always_ff @(posedge clk or negedge rst_n)
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
      end else if (en) begin
        v_q <= v_d;
        c_q <= co;
      end
    if (k == 0) begin : g_first
      assign a_d = io.a;
      assign b_d = io.b ^ {WIDTH{io.sub}};
      assign c_d = io.cin ^ io.sub;
      assign v_d = io.op_valid;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s_q <= '0;
        else if (en) s_q <= sum;
    end else begin : g_next
      assign a_d = g_st[k-1].g_fwd.a_q;
      assign b_d = g_st[k-1].g_fwd.b_q;
      assign c_d = g_st[k-1].c_q;
      assign v_d = g_st[k-1].v_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) s_q <= '0;
        else if (en) s_q <= {sum, g_st[k-1].s_q};
    end
    // Operand bits not yet consumed ride along with their transaction.
    if (k < STAGES - 1) begin : g_fwd
      logic [RW-CW-1:0] a_q, b_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_d[RW-1:CW];
          b_q <= b_d[RW-1:CW];
        end
    end
    // Carry into the MSB is recovered as a^b^s at that bit.
    if (k == STAGES - 1) begin : g_last
      logic o_q;
      always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) o_q <= 1'b0;
        else if (en) o_q <= co ^ a_d[CW-1] ^ b_d[CW-1] ^ sum[CW-1];
    end
  end
  assign en           = ~g_st[STAGES-1].v_q | io.res_ready;
  assign io.op_ready  = en;
  assign io.res_valid = g_st[STAGES-1].v_q;
  assign io.s         = g_st[STAGES-1].s_q;
  assign io.cout      = g_st[STAGES-1].c_q;
  assign io.ovf       = g_st[STAGES-1].g_last.o_q;
endmodule

// File: tb/tb_lcla_pipe_adder.sv
// tb_lcla_pipe_adder: directed checks of the pipelined lookahead adder in three configurations
module tb_lcla_pipe_adder;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int vec_cnt = 0;
  int err_cnt = 0;
  lcla_pipe_adder_if #(.WIDTH(16)) io16 ();
  lcla_pipe_adder_if #(.WIDTH(32)) io32a ();
  lcla_pipe_adder_if #(.WIDTH(32)) io32b ();
  lcla_pipe_adder #(.WIDTH(16), .STAGES(4)) dut16 (.clk(clk), .rst_n(rst_n), .io(io16.slave));
  lcla_pipe_adder #(.WIDTH(32), .STAGES(1)) dut1 (.clk(clk), .rst_n(rst_n), .io(io32a.slave));
  lcla_pipe_adder #(.WIDTH(32), .STAGES(8)) dut8 (.clk(clk), .rst_n(rst_n), .io(io32b.slave));
  logic [31:0] s_w [3];
  logic        v_w [3];
  assign s_w[0] = {16'h0, io16.s};
  assign s_w[1] = io32a.s;
  assign s_w[2] = io32b.s;
  assign v_w[0] = io16.res_valid;
  assign v_w[1] = io32a.res_valid;
  assign v_w[2] = io32b.res_valid;
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic single(input string tag, input logic [15:0] a, input logic [15:0] b, input logic cin,
                        input logic sub, input logic [15:0] es, input logic ec, input logic eo);
    @(negedge clk);
    io16.a = a;
    io16.b = b;
    io16.cin = cin;
    io16.sub = sub;
    io16.op_valid = 1'b1;
    @(negedge clk);
    io16.op_valid = 1'b0;
    repeat (2) @(negedge clk);
    check({tag, "_early"}, io16.res_valid, 0);
    @(negedge clk);
    check({tag, "_v"}, io16.res_valid, 1);
    check({tag, "_s"}, io16.s, es);
    check({tag, "_c"}, io16.cout, ec);
    check({tag, "_o"}, io16.ovf, eo);
  endtask
  task automatic mon(input int d, input int lat, input int w);
    int n, got, first;
    logic [31:0] m;
    m = (w == 32) ? 32'hFFFF_FFFF : 32'h0000_FFFF;
    got = 0;
    first = -1;
    for (n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (v_w[d]) begin
        if (got == 0) first = n;
        check($sformatf("d%0d_s%0d", d, got), s_w[d], (32'(2 * (32760 + got))) & m);
        got++;
        if (got == 15) break;
      end
    end
    check($sformatf("d%0d_first", d), first, lat);
    check($sformatf("d%0d_count", d), got, 15);
    check($sformatf("d%0d_rate", d), n - first, 14);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int sent, got;
    logic [15:0] held;
    {io16.a, io16.b, io16.cin, io16.sub, io16.op_valid} = '0;
    {io32a.a, io32a.b, io32a.cin, io32a.sub, io32a.op_valid} = '0;
    {io32b.a, io32b.b, io32b.cin, io32b.sub, io32b.op_valid} = '0;
    io16.res_ready = 1'b1;
    io32a.res_ready = 1'b1;
    io32b.res_ready = 1'b1;
    #2;
    check("rst_v", io16.res_valid, 0);
    check("rst_s", io16.s, 0);
    check("rst_rdy", io16.op_ready, 1);
    check("rst_v1", v_w[1], 0);
    check("rst_v8", v_w[2], 0);
    @(negedge clk);
    rst_n = 1'b1;
    single("add_ovf", 16'h7FFF, 16'h7FFF, 1'b0, 1'b0, 16'hFFFE, 1'b1 ^ 1'b1, 1'b1);
    single("add_cin", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0);
    single("sub_neg", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    single("sub_m1", 16'h000A, 16'h0003, 1'b1, 1'b1, 16'h0006, 1'b1, 1'b0);
    io16.cin = 1'b0;
    io16.sub = 1'b0;
    @(negedge clk);
    fork
      begin
        for (int i = 0; i < 15; i++) begin
          io16.a = 16'(32760 + i);
          io16.b = 16'(32760 + i);
          io32a.a = 32'(32760 + i);
          io32a.b = 32'(32760 + i);
          io32b.a = 32'(32760 + i);
          io32b.b = 32'(32760 + i);
          io16.op_valid = 1'b1;
          io32a.op_valid = 1'b1;
          io32b.op_valid = 1'b1;
          @(negedge clk);
        end
        io16.op_valid = 1'b0;
        io32a.op_valid = 1'b0;
        io32b.op_valid = 1'b0;
      end
      mon(0, 4, 16);
      mon(1, 1, 32);
      mon(2, 8, 32);
    join
    sent = 0;
    got = 0;
    held = '0;
    for (int cyc = 0; cyc < 40 && got < 8; cyc++) begin
      @(negedge clk);
      io16.res_ready = !(cyc >= 6 && cyc < 9);
      io16.op_valid = sent < 8;
      io16.a = 16'(100 + sent);
      io16.b = 16'(100 + sent);
      #1;
      if (cyc == 6) held = io16.s;
      if (cyc >= 6 && cyc < 9) begin
        check("stall_rdy", io16.op_ready, 0);
        check("stall_v", io16.res_valid, 1);
      end
      if (cyc >= 7 && cyc < 9) check("stall_s", io16.s, held);
      if (io16.op_valid && io16.op_ready) sent++;
      if (io16.res_valid && io16.res_ready) begin
        check($sformatf("stall_r%0d", got), io16.s, 16'(200 + 2 * got));
        got++;
      end
    end
    io16.op_valid = 1'b0;
    io16.res_ready = 1'b1;
    check("stall_cnt", got, 8);
    check("stall_sent", sent, 8);
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      io16.a = 16'(i + 1);
      io16.b = 16'h0000;
      io16.op_valid = 1'b1;
      io32a.a = 32'(i + 1);
      io32a.op_valid = 1'b1;
      @(negedge clk);
    end
    io16.op_valid = 1'b0;
    io32a.op_valid = 1'b0;
    check("pre_rst_v", io16.res_valid, 1);
    check("pre_rst_s", io16.s, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_v", io16.res_valid, 0);
    check("mid_rst_s", io16.s, 0);
    check("mid_rst_c", io16.cout, 0);
    check("mid_rst_rdy", io16.op_ready, 1);
    check("mid_rst_v1", v_w[1], 0);
    check("mid_rst_s1", s_w[1], 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check($sformatf("post_rst_v%0d", i), io16.res_valid, 0);
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
